add_seq: RTL and testbench

Multi-cycle wide-add sequencer. It computes a WORDS×8-bit sum by stepping one shared 8-bit ripple adder slice through the operands, one byte per clock, least-significant byte first, chaining the carry through a register. It sits between a requester and the existing 8-bit adder datapath, and trades latency for area in wide arithmetic paths. Valid/ready handshakes are used on both the operand side and the result side.

---
 rtl/add_seq_pkg.sv | 14 +
 rtl/add_seq_if.sv | 34 +++
 rtl/add_seq_slice8.sv | 35 +++
 rtl/add_seq.sv | 105 ++++++++++
 tb/tb_add_seq.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the add_seq multi-cycle wide adder.
// Subtract support is controlled by the ADD_SEQ_SUB_EN macro.
package add_seq_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The byte index is at least 1 bit wide, so WORDS=1 still has a register.
  function automatic int unsigned idx_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_seq_if.sv
// Operand/result handshake bundle for add_seq.
// op_sub is present only when ADD_SEQ_SUB_EN is defined.
interface add_seq_if import add_seq_pkg::*; #(parameter int unsigned WORDS = 4);

  logic                       in_valid;
  logic                       in_ready;
  logic [SLICE_W*WORDS-1:0]   a;
  logic [SLICE_W*WORDS-1:0]   b;
  logic                       cin;
`ifdef ADD_SEQ_SUB_EN
  logic                       op_sub;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [SLICE_W*WORDS-1:0]   sum;
  logic                       cout;

  modport master (
`ifdef ADD_SEQ_SUB_EN
    output op_sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
`ifdef ADD_SEQ_SUB_EN
    input  op_sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/add_seq_slice8.sv
// Combinational 8-bit ripple-carry slice built from 1-bit full-adder cells.
module add_fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_slice8 import add_seq_pkg::*; (
  input  logic [SLICE_W-1:0] a8,
  input  logic [SLICE_W-1:0] b8,
  input  logic               ci,
  output logic [SLICE_W-1:0] s8,
  output logic               co
);
  logic [SLICE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    add_fa1 u_fa (
      .a  (a8[i]),
      .b  (b8[i]),
      .ci (c[i]),
      .s  (s8[i]),
      .co (c[i+1])
    );
  end

  assign co = c[SLICE_W];
endmodule

// File: rtl/add_seq.sv
// Multi-cycle WORDS x 8-bit adder stepping one shared slice LSB-first.
// Define ADD_SEQ_SUB_EN to add the op_sub (a - b) mode.
module add_seq import add_seq_pkg::*; #(
  parameter int unsigned WORDS = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  add_seq_if.slave  bus
);

  localparam int unsigned     W    = SLICE_W * WORDS;
  localparam int unsigned     IW   = idx_w(WORDS);
  localparam logic [IW-1:0]   LAST = IW'(WORDS - 1);

  state_t              state;
  logic [IW-1:0]       idx;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        sum_r;
  logic                carry;
  logic                cout_r;
`ifdef ADD_SEQ_SUB_EN
  logic                sub_r;
`endif

  logic [SLICE_W-1:0]  a8;
  logic [SLICE_W-1:0]  b8;
  logic [SLICE_W-1:0]  s8;
  logic                co;

  always_comb begin
    a8 = '0;
    b8 = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) begin
        a8 = a_r[i*SLICE_W +: SLICE_W];
        b8 = b_r[i*SLICE_W +: SLICE_W];
      end
    end
`ifdef ADD_SEQ_SUB_EN
    if (sub_r) b8 = ~b8;
`endif
  end

  add_slice8 u_slice (
    .a8 (a8),
    .b8 (b8),
    .ci (carry),
    .s8 (s8),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      sub_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            idx   <= '0;
            state <= RUN;
`ifdef ADD_SEQ_SUB_EN
            sub_r <= bus.op_sub;
            carry <= bus.op_sub ? 1'b1 : bus.cin;
`else
            carry <= bus.cin;
`endif
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) sum_r[i*SLICE_W +: SLICE_W] <= s8;
          end
          carry <= co;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            cout_r <= co;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq: WORDS=4 and WORDS=1 instances.
module tb_add_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_seq_if #(.WORDS(4)) i4 ();
  add_seq_if #(.WORDS(1)) i1 ();

  add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  add_seq #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands to the WORDS=4 instance and take the accept edge.
  task automatic issue4(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sub);
    i4.a = av;
    i4.b = bv;
    i4.cin = ci;
`ifdef ADD_SEQ_SUB_EN
    i4.op_sub = sub;
`else
    if (sub) $display("note: %s requests subtract without ADD_SEQ_SUB_EN", tag);
`endif
    i4.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(i4.in_ready), 64'd1);
    tick();
    i4.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid after an accept, then check latency and result.
  task automatic result4(input string tag, input logic [31:0] es, input logic ec);
    int n = 0;
    while (!i4.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    chk({tag, "_sum"}, 64'(i4.sum), 64'(es));
    chk({tag, "_cout"}, 64'(i4.cout), 64'(ec));
  endtask

  task automatic release4(input string tag);
    i4.out_ready = 1'b1;
    tick();
    i4.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 64'(i4.out_valid), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(i4.in_ready), 64'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    i4.in_valid = 1'b0; i4.out_ready = 1'b0; i4.a = '0; i4.b = '0; i4.cin = 1'b0;
    i1.in_valid = 1'b0; i1.out_ready = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    i4.op_sub = 1'b0;
    i1.op_sub = 1'b0;
`endif
    #3;
    chk("rst_in_ready", 64'(i4.in_ready), 64'd1);
    chk("rst_out_valid", 64'(i4.out_valid), 64'd0);
    chk("rst_sum", 64'(i4.sum), 64'd0);
    chk("rst_cout", 64'(i4.cout), 64'd0);
    chk("rst1_in_ready", 64'(i1.in_ready), 64'd1);
    chk("rst1_sum", 64'(i1.sum), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    // Full ripple across all bytes
    issue4("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    result4("ripple", 32'h0000_0000, 1'b1);
    release4("ripple");

    issue4("interbyte", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0);
    result4("interbyte", 32'h0100_0100, 1'b0);
    release4("interbyte");

    issue4("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    result4("cin", 32'h2345_678A, 1'b0);
    release4("cin");

    // Backpressure: result held while new operands are offered
    issue4("bp_first", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    result4("bp_first", 32'h0000_0003, 1'b0);
    i4.a = 32'h8000_0000;
    i4.b = 32'h8000_0000;
    i4.cin = 1'b0;
    i4.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", 64'(i4.out_valid), 64'd1);
      chk("bp_in_ready", 64'(i4.in_ready), 64'd0);
      chk("bp_sum", 64'(i4.sum), 64'h3);
      chk("bp_cout", 64'(i4.cout), 64'd0);
    end
    i4.out_ready = 1'b1;
    tick();
    i4.out_ready = 1'b0;
    chk("bp_idle_out_valid", 64'(i4.out_valid), 64'd0);
    chk("bp_idle_in_ready", 64'(i4.in_ready), 64'd1);
    chk("bp_idle_sum_kept", 64'(i4.sum), 64'h3);
    tick();
    i4.in_valid = 1'b0;
    chk("bp_accepted", 64'(i4.in_ready), 64'd0);
    result4("bp_second", 32'h0000_0000, 1'b1);
    release4("bp_second");

    // Asynchronous reset two RUN cycles into an operation
    issue4("rst_mid", 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_mid_partial", 64'(i4.sum[15:0]), 64'h0202);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(i4.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(i4.in_ready), 64'd1);
    chk("rst_mid_sum", 64'(i4.sum), 64'd0);
    chk("rst_mid_cout", 64'(i4.cout), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    issue4("after_rst", 32'd3, 32'd4, 1'b0, 1'b0);
    result4("after_rst", 32'd7, 1'b0);
    release4("after_rst");

    // Single-byte instance
    i1.a = 8'hFF;
    i1.b = 8'h01;
    i1.cin = 1'b1;
    i1.in_valid = 1'b1;
    tick();
    i1.in_valid = 1'b0;
    n = 0;
    while (!i1.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("w1_latency", 64'(n), 64'd1);
    chk("w1_sum", 64'(i1.sum), 64'h01);
    chk("w1_cout", 64'(i1.cout), 64'd1);
    i1.out_ready = 1'b1;
    tick();
    i1.out_ready = 1'b0;
    chk("w1_in_ready_back", 64'(i1.in_ready), 64'd1);

`ifdef ADD_SEQ_SUB_EN
    issue4("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1);
    result4("sub_borrow", 32'hFFFF_FFFE, 1'b0);
    release4("sub_borrow");
    issue4("sub_noborrow", 32'd7, 32'd5, 1'b0, 1'b1);
    result4("sub_noborrow", 32'h0000_0002, 1'b1);
    release4("sub_noborrow");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
